// File: rtl/alu_sched.sv
// Round-robin scheduler that lets two requesters share one combinational ALU.
// Optional macro ALU_SCHED_DIVZERO_EN adds a divide-by-zero override and the err flag.
//
// state | meaning
// IDLE  | waiting; requests are sampled and arbitrated here
// ISSUE | latched operands drive the ALU, gnt of the winner high, result captured
// DONE  | done of the winner high, op_cnt advances on exit
module alu_sched #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [7:0]       a0,
   input  logic [7:0]       b0,
   input  logic [7:0]       a1,
   input  logic [7:0]       b1,
   input  logic [3:0]       sel0,
   input  logic [3:0]       sel1,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [3:0]       alu_sel,
   input  logic [7:0]       alu_out,
   input  logic             alu_cout,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [7:0]       result,
   output logic             carry,
   output logic             err,
   output logic             busy,
   output logic [CNT_W-1:0] op_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t state, state_nxt;
   logic   owner;
   logic   last;
   logic   win;
   logic   start;
   logic   div_zero;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      win       = last;
      start     = 1'b0;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      done0     = 1'b0;
      done1     = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               start     = 1'b1;
               // On contention the requester not served last goes next.
               win       = (req0 && req1) ? ~last : req1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            gnt0      = ~owner;
            gnt1      = owner;
            state_nxt = DONE;
         end
         DONE: begin
            done0     = ~owner;
            done1     = owner;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

`ifdef ALU_SCHED_DIVZERO_EN
   assign div_zero = (alu_sel == 4'b0011) && (alu_b == 8'h00);
`else
   assign div_zero = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner   <= 1'b0;
         last    <= 1'b1;
         alu_a   <= 8'h00;
         alu_b   <= 8'h00;
         alu_sel <= 4'h0;
         result  <= 8'h00;
         carry   <= 1'b0;
         err     <= 1'b0;
         op_cnt  <= '0;
      end else begin
         // Operand latches double as the ALU drive, so they stay still when idle.
         if (start) begin
            owner   <= win;
            last    <= win;
            alu_a   <= win ? a1 : a0;
            alu_b   <= win ? b1 : b0;
            alu_sel <= win ? sel1 : sel0;
         end
         if (state == ISSUE) begin
            result <= div_zero ? 8'h00 : alu_out;
            carry  <= div_zero ? 1'b0 : alu_cout;
            err    <= div_zero;
         end
         if (state == DONE) op_cnt <= op_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small behavioural ALU attached.
// Built with CNT_W=2 so the op counter wrap is exercised.
module tb_alu_sched;

   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0, req1;
   logic [7:0]       a0, b0, a1, b1;
   logic [3:0]       sel0, sel1;
   logic [7:0]       alu_a, alu_b;
   logic [3:0]       alu_sel;
   logic [7:0]       alu_out;
   logic             alu_cout;
   logic             gnt0, gnt1, done0, done1;
   logic [7:0]       result;
   logic             carry, err, busy;
   logic [CNT_W-1:0] op_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   alu_sched #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .sel0(sel0), .sel1(sel1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_cout(alu_cout),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .carry(carry), .err(err), .busy(busy),
      .op_cnt(op_cnt)
   );

   always #5 clk = ~clk;

   // Reference ALU: add, subtract, and, divide (b=0 gives FF), xor otherwise.
   always_comb begin
      alu_out  = 8'h00;
      alu_cout = 1'b0;
      case (alu_sel)
         4'b0000: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         4'b0001: {alu_cout, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
         4'b0010: alu_out = alu_a & alu_b;
         4'b0011: alu_out = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
         default: alu_out = alu_a ^ alu_b;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // One uncontended op from requester r, launched from IDLE.
   task automatic single_op(input bit r, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] s, input logic [7:0] exp_res,
                            input bit exp_c, input bit exp_e, input logic [31:0] exp_cnt);
      if (r) begin req1 = 1'b1; a1 = a; b1 = b; sel1 = s; end
      else   begin req0 = 1'b1; a0 = a; b0 = b; sel0 = s; end
      cyc();
      req0 = 1'b0; req1 = 1'b0;
      // Disturb the operands while the op is in flight.
      a0 = 8'h5A; b0 = 8'hA5; a1 = 8'h3C; b1 = 8'hC3; sel0 = 4'b0010; sel1 = 4'b0010;
      chk("issue_gnt0", gnt0, !r);
      chk("issue_gnt1", gnt1, r);
      chk("issue_alu_a", alu_a, a);
      chk("issue_alu_b", alu_b, b);
      chk("issue_alu_sel", alu_sel, s);
      chk("issue_busy", busy, 1);
      cyc();
      chk("done_done0", done0, !r);
      chk("done_done1", done1, r);
      chk("done_gnt", {gnt0, gnt1}, 0);
      chk("done_result", result, exp_res);
      chk("done_carry", carry, exp_c);
      chk("done_err", err, exp_e);
      cyc();
      chk("idle_busy", busy, 0);
      chk("idle_op_cnt", op_cnt, exp_cnt);
      chk("idle_alu_a_hold", alu_a, a);
      chk("idle_done", {done0, done1}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00; sel0 = 4'h0; sel1 = 4'h0;
      cyc(); cyc();
      chk("rst_busy", busy, 0);
      chk("rst_gnt_done", {gnt0, gnt1, done0, done1}, 0);
      chk("rst_result", result, 0);
      chk("rst_op_cnt", op_cnt, 0);
      chk("rst_alu_drive", {alu_a, alu_b, alu_sel}, 0);
      chk("rst_err_carry", {err, carry}, 0);
      rst = 1'b1;
      cyc();

      // 0A+0B, then FF+01 with carry out
      single_op(1'b0, 8'h0A, 8'h0B, 4'b0000, 8'h15, 1'b0, 1'b0, 1);
      single_op(1'b1, 8'hFF, 8'h01, 4'b0000, 8'h00, 1'b1, 1'b0, 2);

      // Both requesters held: last served was 1, so 0 goes first.
      req0 = 1'b1; a0 = 8'h01; b0 = 8'h02; sel0 = 4'b0000;
      req1 = 1'b1; a1 = 8'h05; b1 = 8'h07; sel1 = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         logic [1:0] exp_cnt;
         exp_cnt = 2'(3 + k);
         cyc();
         chk("cont_gnt0", gnt0, (k % 2) == 0);
         chk("cont_gnt1", gnt1, (k % 2) == 1);
         cyc();
         chk("cont_done0", done0, (k % 2) == 0);
         chk("cont_done1", done1, (k % 2) == 1);
         chk("cont_result", result, ((k % 2) == 0) ? 8'h03 : 8'h0C);
         if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
         cyc();
         chk("cont_op_cnt", op_cnt, exp_cnt);
      end
      cyc();
      chk("cont_idle", busy, 0);

`ifdef ALU_SCHED_DIVZERO_EN
      single_op(1'b0, 8'h10, 8'h00, 4'b0011, 8'h00, 1'b0, 1'b1, 3);
`else
      single_op(1'b0, 8'h10, 8'h00, 4'b0011, 8'hFF, 1'b0, 1'b0, 3);
`endif
      single_op(1'b0, 8'h10, 8'h04, 4'b0011, 8'h04, 1'b0, 1'b0, 0);

      // Reset while requester 0 holds its grant.
      req0 = 1'b1; a0 = 8'h20; b0 = 8'h22; sel0 = 4'b0000;
      cyc();
      req0 = 1'b0;
      chk("abort_gnt0_before", gnt0, 1);
      #1 rst = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_gnt_done", {gnt0, gnt1, done0, done1}, 0);
      chk("abort_result", result, 0);
      chk("abort_op_cnt", op_cnt, 0);
      cyc();
      chk("abort_no_done0", done0, 0);
      rst = 1'b1;
      single_op(1'b1, 8'h30, 8'h01, 4'b0001, 8'h2F, 1'b0, 1'b0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 Parameter: CNT_W, default 8, width of completed-operation counter op_cnt.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 a0, b0, a1, b1  input  8 each  operands of requester 0 / 1.
REQ-006 sel0, sel1  input  4 each  ALU opcode of requester 0 / 1, using the team ALU 16-op encoding (0011 = divide).
REQ-007 alu_a, alu_b  output  8 each  operands driven to the shared ALU.
REQ-008 alu_sel  output  4  opcode driven to the shared ALU.
REQ-009 alu_out  input  8  ALU result, combinational from alu_a/alu_b/alu_sel.
REQ-010 alu_cout  input  1  ALU carry-out.
REQ-011 gnt0, gnt1  output  1 each  one-cycle grant pulse.
REQ-012 done0, done1  output  1 each  one-cycle completion pulse; result valid.
REQ-013 result  output  8  registered ALU result of the last completed operation.
REQ-014 carry  output  1  registered alu_cout of the last completed operation.
REQ-015 err  output  1  divide-by-zero flag of the last completed operation.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 op_cnt  output  CNT_W  count of completed operations.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE and DONE only.
REQ-019 IDLE: at a rising edge with req0 or req1 high -> ISSUE; a, b and sel of the winner latched; no request -> stay IDLE.
REQ-020 Arbitration SHALL be round-robin: single requester wins; both high -> requester not granted last wins; after reset requester 0 wins first.
REQ-021 ISSUE (exactly 1 cycle): gnt of the winner high; alu_a/alu_b/alu_sel = latched values; next edge captures alu_out -> result, alu_cout -> carry; -> DONE.
REQ-022 DONE (exactly 1 cycle): done of the winner high; op_cnt increments at the edge leaving DONE; -> IDLE.
REQ-023 Latency: request sampled at edge N -> gnt high cycle N+1, done high cycle N+2, IDLE cycle N+3; max throughput one operation per 3 cycles.
REQ-024 Requests SHALL be sampled only in IDLE; req held high past its done is a new request, arbitrated with the other requester.
REQ-025 Operands and opcode change during ISSUE/DONE SHALL NOT affect the operation in flight.
REQ-026 alu_a/alu_b/alu_sel SHALL hold the latched values outside ISSUE (no toggling when idle).
REQ-027 result, carry, err SHALL hold until the next capture.
REQ-028 op_cnt SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-029 At most one of gnt0/gnt1/done0/done1 high in any cycle.

Reset
REQ-030 rst low SHALL immediately force state IDLE, round-robin pointer to "last = 1", and clear result, carry, err, op_cnt, alu_a, alu_b, alu_sel, gnt*, done*, busy to 0.
REQ-031 Reset mid-operation SHALL abort it: no done pulse, op_cnt unchanged from 0; first edge after rst release samples requests normally.

Configuration
REQ-032 Macro ALU_SCHED_DIVZERO_EN.
REQ-033 Defined: capture with latched sel = 0011 and latched b = 0 SHALL force result = 8'h00, carry = 0, err = 1; any other capture clears err; timing unchanged.
REQ-034 Undefined: err SHALL be constant 0; divide operations captured from alu_out like any other op.

Verification
REQ-035 Single op: req0, a0=8'h0A, b0=8'h0B, sel0=0000 -> gnt0 cycle N+1, done0 cycle N+2, result=8'h15, carry=0, op_cnt=1.
REQ-036 Contention: req0 and req1 held high from reset release -> grants alternate 0,1,0,1; each done matches its gnt; op_cnt increments by 1 per done.
REQ-037 Carry: a1=8'hFF, b1=8'h01, sel1=0000 -> result=8'h00, carry=1, done1 pulsed.
REQ-038 Divide by zero with ALU_SCHED_DIVZERO_EN: a0=8'h10, b0=8'h00, sel0=0011 -> result=8'h00, err=1; next op a0=8'h10, b0=8'h04, sel0=0011 -> result=8'h04, err=0.
REQ-039 Reset in ISSUE: rst low while gnt0 high -> busy=0, no done0, result=0, op_cnt=0 immediately; after release req1 alone is granted.
REQ-040 Wrap: CNT_W=2, five completed ops -> op_cnt sequence 1,2,3,0,1.
